// File: rtl/div_seq_pkg.sv
// Shared constants for the divide sequencer: widths, FSM encodings, handshake levels.
// Signed support in div_seq is selected with the DIV_SIGNED_EN macro.
package div_seq_pkg;

    localparam int WordWidth   = 32;
    localparam int ResultWidth = 64;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [WordWidth-1:0]   ZeroWord  = '0;
    localparam logic [ResultWidth-1:0] ZeroDword = '0;

    // {rem[32:0], quot[31:0]}; the extra remainder bit absorbs the shift-out
    typedef logic [64:0] div_work_t;

    function automatic logic [WordWidth-1:0] neg_word(input logic [WordWidth-1:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// EX <-> divide sequencer request/result bundle.
interface div_seq_if;
    import div_seq_pkg::*;

    logic                   start_i;
    logic                   signed_i;
    logic [WordWidth-1:0]   opdata1_i;
    logic [WordWidth-1:0]   opdata2_i;
    logic                   annul_i;
    logic [ResultWidth-1:0] result_o;
    logic                   ready_o;
    logic                   stallreq_o;

    modport master (
        output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, stallreq_o
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on the 65-bit {rem, quot} register.
module div_step
    import div_seq_pkg::*;
(
    input  div_work_t            work_in,
    input  logic [WordWidth-1:0] divisor,
    output div_work_t            work_out
);

    logic [33:0] trial;

    // work_in[64:31] is the shifted remainder with one guard bit; trial[33] flags a borrow
    always_comb begin
        trial    = work_in[64:31] - {2'b00, divisor};
        work_out = {work_in[63:0], 1'b0};
        if (!trial[33]) begin
            work_out[64:32] = trial[32:0];
            work_out[0]     = 1'b1;
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divide sequencer with pipeline stall request.
// Define DIV_SIGNED_EN to honour signed_i; otherwise every divide is unsigned.
module div_seq
    import div_seq_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    div_seq_if.slave bus
);

    logic [1:0]             state;
    logic [5:0]             cnt;
    div_work_t              work;
    div_work_t              work_next;
    logic [WordWidth-1:0]   divisor;
    logic [ResultWidth-1:0] result_q;
    logic                   ready_q;
    logic                   accept;
    logic [WordWidth-1:0]   dividend_in;
    logic [WordWidth-1:0]   divisor_in;
    logic [WordWidth-1:0]   quot_fix;
    logic [WordWidth-1:0]   rem_fix;

    assign accept = (bus.start_i == DivStart) && !bus.annul_i;

`ifdef DIV_SIGNED_EN
    logic op1_neg;
    logic op2_neg;
    logic neg_quot;
    logic neg_rem;

    assign op1_neg     = bus.signed_i && bus.opdata1_i[31];
    assign op2_neg     = bus.signed_i && bus.opdata2_i[31];
    assign dividend_in = op1_neg ? neg_word(bus.opdata1_i) : bus.opdata1_i;
    assign divisor_in  = op2_neg ? neg_word(bus.opdata2_i) : bus.opdata2_i;
    assign quot_fix    = neg_quot ? neg_word(work[31:0])  : work[31:0];
    assign rem_fix     = neg_rem  ? neg_word(work[63:32]) : work[63:32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (state == DivFree && accept) begin
            neg_quot <= op1_neg ^ op2_neg;
            neg_rem  <= op1_neg;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = bus.signed_i;
    assign dividend_in   = bus.opdata1_i;
    assign divisor_in    = bus.opdata2_i;
    assign quot_fix      = work[31:0];
    assign rem_fix       = work[63:32];
`endif

    div_step u_step (
        .work_in  (work),
        .divisor  (divisor),
        .work_out (work_next)
    );

    // The zero-divisor path reuses cnt to spend two edges in BYZERO before END
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DivFree;
            cnt      <= 6'd0;
            work     <= '0;
            divisor  <= ZeroWord;
            result_q <= ZeroDword;
            ready_q  <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    if (accept) begin
                        cnt <= 6'd0;
                        if (bus.opdata2_i == ZeroWord) begin
                            state <= DivByZero;
                        end else begin
                            state   <= DivOn;
                            work    <= {33'd0, dividend_in};
                            divisor <= divisor_in;
                        end
                    end
                end
                DivByZero: begin
                    if (cnt == 6'd0) begin
                        cnt <= 6'd1;
                    end else begin
                        state    <= DivEnd;
                        cnt      <= 6'd0;
                        result_q <= ZeroDword;
                        ready_q  <= DivResultReady;
                    end
                end
                DivOn: begin
                    if (!accept) begin
                        state <= DivFree;
                        cnt   <= 6'd0;
                    end else if (cnt != 6'd32) begin
                        work <= work_next;
                        cnt  <= cnt + 6'd1;
                    end else begin
                        state    <= DivEnd;
                        cnt      <= 6'd0;
                        result_q <= {rem_fix, quot_fix};
                        ready_q  <= DivResultReady;
                    end
                end
                default: begin
                    if (bus.annul_i || bus.start_i == DivStop) begin
                        state    <= DivFree;
                        result_q <= ZeroDword;
                        ready_q  <= DivResultNotReady;
                    end
                end
            endcase
        end
    end

    assign bus.stallreq_o = rst_n && ((state == DivByZero) || (state == DivOn) ||
                                      (state == DivFree && accept));
    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq: vector table, hand-written corner sequences, random ops vs a reference model.
module tb_div_seq;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    div_seq_if bus ();

    div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    // Reference: plain integer division; remainder follows the dividend's sign
    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        logic   use_signed;
        use_signed = 1'b0;
`ifdef DIV_SIGNED_EN
        use_signed = sgn;
`endif
        if (b == 32'd0) return 64'd0;
        if (use_signed) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns once ready_o is seen or the bound expires
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 output logic [63:0] res, output int lat, output logic stall_free,
                                 output logic stall_busy, output logic stall_done);
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.signed_i  = sgn;
        bus.annul_i   = 1'b0;
        bus.start_i   = 1'b1;
        #1 stall_free = bus.stallreq_o;
        @(posedge clk); #1;
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
        bus.signed_i  = 1'($urandom_range(0, 1));
        lat        = 0;
        stall_busy = 1'b1;
        while (bus.ready_o !== 1'b1 && lat < 60) begin
            if (bus.stallreq_o !== 1'b1) stall_busy = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res        = bus.result_o;
        stall_done = bus.stallreq_o;
    endtask

    task automatic releaseAndCheck(input string name);
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        checkOutput({name, " ready drop"}, {63'd0, bus.ready_o}, 64'd0);
        checkOutput({name, " result clear"}, bus.result_o, 64'd0);
    endtask

    task automatic runVector(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic sgn, input logic [63:0] exp);
        logic [63:0] res;
        int          lat;
        logic        sf, sb, sd;
        applyStimulus(a, b, sgn, res, lat, sf, sb, sd);
        checkOutput({name, " result"}, res, exp);
        checkOutput({name, " latency"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
        checkOutput({name, " stall"}, {61'd0, sf, sb, sd}, 64'b110);
        releaseAndCheck(name);
    endtask

    task automatic setVec(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp);
        vecs[i].a   = a;
        vecs[i].b   = b;
        vecs[i].sgn = sgn;
        vecs[i].exp = exp;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog abort");
    end

    initial begin
        logic [63:0] res;
        logic [63:0] held;
        logic [31:0] ra, rb;
        logic        rs;
        int          lat;
        logic        sf, sb, sd;
        logic        saw_ready;

        setVec(0, 32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
        setVec(3, 32'd5, 32'd0, 1'b1, 64'd0);
        setVec(5, 32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF});
        setVec(6, 32'd3, 32'd10, 1'b0, {32'd3, 32'd0});
        setVec(7, 32'hFFFF_FFF9, 32'd2, 1'b0, {32'd1, 32'h7FFF_FFFC});
        setVec(8, 32'd9, 32'd3, 1'b0, {32'd0, 32'd3});
`ifdef DIV_SIGNED_EN
        setVec(1, 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        setVec(2, 32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD});
        setVec(4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000});
        setVec(9, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, {32'hFFFF_FFFE, 32'd2});
`else
        setVec(1, 32'hFFFF_FFF9, 32'd2, 1'b1, {32'd1, 32'h7FFF_FFFC});
        setVec(2, 32'd7, 32'hFFFF_FFFE, 1'b1, {32'd7, 32'd0});
        setVec(4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'd0});
        setVec(9, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, {32'hFFFF_FFF8, 32'd0});
`endif

        // Reset state, with a request pending to show stall is held off in reset
        rst_n         = 1'b0;
        bus.start_i   = 1'b1;
        bus.signed_i  = 1'b0;
        bus.annul_i   = 1'b0;
        bus.opdata1_i = 32'd1;
        bus.opdata2_i = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ready", {63'd0, bus.ready_o}, 64'd0);
        checkOutput("reset result", bus.result_o, 64'd0);
        checkOutput("reset stall", {63'd0, bus.stallreq_o}, 64'd0);
        bus.start_i = 1'b0;
        rst_n       = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp);
        end

        // Result is held while start stays high in END
        applyStimulus(32'd100, 32'd7, 1'b0, res, lat, sf, sb, sd);
        held = res;
        @(posedge clk); #1;
        checkOutput("hold ready", {63'd0, bus.ready_o}, 64'd1);
        checkOutput("hold result", bus.result_o, {32'd2, 32'd14});
        checkOutput("hold first", held, {32'd2, 32'd14});
        releaseAndCheck("hold");

        // Annul at iteration 10, then a clean follow-up request
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.signed_i  = 1'b0;
        bus.start_i   = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
        checkOutput("annul stall", {63'd0, bus.stallreq_o}, 64'd0);
        checkOutput("annul ready", {63'd0, bus.ready_o}, 64'd0);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        saw_ready   = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.ready_o !== 1'b0) saw_ready = 1'b1;
        end
        checkOutput("annul no ready", {63'd0, saw_ready}, 64'd0);
        runVector("after annul", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3});

        // Dropping start mid-operation abandons it
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        checkOutput("drop stall", {63'd0, bus.stallreq_o}, 64'd0);
        saw_ready = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.ready_o !== 1'b0) saw_ready = 1'b1;
        end
        checkOutput("drop no ready", {63'd0, saw_ready}, 64'd0);

        // Asynchronous reset while iterating
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst on stall", {63'd0, bus.stallreq_o}, 64'd0);
        checkOutput("rst on ready", {63'd0, bus.ready_o}, 64'd0);
        bus.start_i = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        runVector("after rst on", 32'd50, 32'd6, 1'b0, {32'd2, 32'd8});

        // Asynchronous reset while holding a result
        applyStimulus(32'd20, 32'd6, 1'b0, res, lat, sf, sb, sd);
        checkOutput("rst end pre", res, {32'd2, 32'd3});
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst end ready", {63'd0, bus.ready_o}, 64'd0);
        checkOutput("rst end result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Random operations against the reference model
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(1, 50);
                3:       rb = -32'($urandom_range(1, 50));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            runVector($sformatf("rand%0d", i), ra, rb, rs, refDiv(ra, rb, rs));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
